// File: rtl/latex_char_packer.sv
`default_nettype none
// ============================================================================
// Module      : latex_char_packer
// Description : Receives the per-character ASCII LaTeX stream, packs two
//               characters per 16-bit word (first char in the high byte),
//               buffers the words in a small FIFO and, on the NUL
//               terminator, reports the character count and XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module latex_char_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CHARS  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  char_count,
    output logic [7:0]  checksum,
    output logic        overflow
);

    localparam int           c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]   c_MAX_CHARS = 8'(MAX_CHARS);
    localparam logic [c_AW:0] c_PTR_ONE  = (c_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Word FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_push_data;

    // Packing / statistics state
    logic          r_pending;
    logic [7:0]    r_high;
    logic [7:0]    r_count;
    logic [7:0]    r_checksum;
    logic          r_overflow;

    logic          w_accept;
    logic          w_is_nul;
    logic          w_at_max;
    logic          w_char_ready;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_accept = char_valid & w_char_ready;
    assign w_is_nul = (char_in == 8'h00);
    assign w_at_max = (r_count == c_MAX_CHARS);

    // A word is produced by the terminator, or by the second char of a pair
    // as long as that char is still being counted (not discarded).
    assign w_push      = w_accept & (w_is_nul | (r_pending & ~w_at_max));
    assign w_push_data = w_is_nul ? (r_pending ? {r_high, 8'h00} : 16'h0000)
                                  : {r_high, char_in};
    assign w_pop       = ~w_empty & word_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        w_char_ready = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_char_ready = ~w_full;
                if (w_accept && w_is_nul) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FIFO pointer update; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // FIFO storage write; contents are only meaningful behind the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_data;
        end
    end

    // Character packing, count, checksum and overflow tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= 1'b0;
            r_high     <= 8'h00;
            r_count    <= 8'h00;
            r_checksum <= 8'h00;
            r_overflow <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_pending  <= 1'b0;
            r_count    <= 8'h00;
            r_checksum <= 8'h00;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            if (w_is_nul) begin
                r_pending <= 1'b0;
            end else if (w_at_max) begin
                r_overflow <= 1'b1;
            end else begin
                r_count    <= r_count + 8'd1;
                r_checksum <= r_checksum ^ char_in;
                if (!r_pending) begin
                    r_high    <= char_in;
                    r_pending <= 1'b1;
                end else begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    assign char_ready = w_char_ready;
    assign word_valid = ~w_empty;
    assign word_out   = w_empty ? 16'h0000 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign char_count = r_count;
    assign checksum   = r_checksum;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_latex_char_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_latex_char_packer
// Description : Directed self-checking bench for latex_char_packer. Two
//               instances share stimulus: one with default limits and one
//               with MAX_CHARS=4 for the saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latex_char_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        word_ready;

    logic        a_char_ready, a_word_valid, a_busy, a_done, a_ovf;
    logic [15:0] a_word_out;
    logic [7:0]  a_count, a_csum;
    logic        b_char_ready, b_word_valid, b_busy, b_done, b_ovf;
    logic [15:0] b_word_out;
    logic [7:0]  b_count, b_csum;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          done_a = 0;
    int          done_b = 0;
    int          n_vec  = 0;
    int          n_bad  = 0;

    latex_char_packer #(.FIFO_DEPTH(4), .MAX_CHARS(255)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .char_in(char_in),
        .char_valid(char_valid), .char_ready(a_char_ready),
        .word_out(a_word_out), .word_valid(a_word_valid), .word_ready(word_ready),
        .busy(a_busy), .done(a_done), .char_count(a_count),
        .checksum(a_csum), .overflow(a_ovf)
    );

    latex_char_packer #(.FIFO_DEPTH(4), .MAX_CHARS(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .char_in(char_in),
        .char_valid(char_valid), .char_ready(b_char_ready),
        .word_out(b_word_out), .word_valid(b_word_valid), .word_ready(word_ready),
        .busy(b_busy), .done(b_done), .char_count(b_count),
        .checksum(b_csum), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    // Capture popped words and done pulses midway between clock edges
    always @(negedge clk) begin
        if (a_word_valid && word_ready) qa.push_back(a_word_out);
        if (b_word_valid && word_ready) qb.push_back(b_word_out);
        if (a_done) done_a++;
        if (b_done) done_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input bit sel_b);
        int n;
        n = 0;
        char_in    = c;
        char_valid = 1'b1;
        while (!(sel_b ? b_char_ready : a_char_ready) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("char_ready_timeout", 32'd0, 32'd1);
        tick();
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    // Waits for the done pulse, checks it lasts one cycle and returns to idle
    task automatic wait_done(input bit sel_b, input string tag);
        int n;
        int d0;
        n  = 0;
        d0 = sel_b ? done_b : done_a;
        while (!(sel_b ? b_done : a_done) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        tick();
        chk({tag, "_done_low"}, sel_b ? b_done : a_done, 1'b0);
        chk({tag, "_busy_low"}, sel_b ? b_busy : a_busy, 1'b0);
        tick();
        chk({tag, "_done_pulses"}, (sel_b ? done_b : done_a) - d0, 32'd1);
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((a_busy || b_busy) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        logic [15:0] exp4 [7];
        exp4 = '{16'h4142, 16'h4344, 16'h4546, 16'h4748, 16'h494A, 16'h4B4C, 16'h0000};

        rst = 1'b1; start = 1'b0; char_in = 8'h00; char_valid = 1'b0; word_ready = 1'b1;
        tick();
        tick();
        chk("rst_char_ready", a_char_ready, 1'b0);
        chk("rst_word_valid", a_word_valid, 1'b0);
        chk("rst_word_out",   a_word_out,   16'h0000);
        chk("rst_busy",       a_busy,       1'b0);
        chk("rst_done",       a_done,       1'b0);
        chk("rst_count",      a_count,      8'h00);
        chk("rst_checksum",   a_csum,       8'h00);
        chk("rst_overflow",   a_ovf,        1'b0);
        rst = 1'b0;
        tick();

        // 1: "s^2"
        wait_idle();
        pulse_start();
        chk("t1_busy", a_busy, 1'b1);
        send(8'h73, 1'b0);
        send(8'h5E, 1'b0);
        chk("t1_first_word_latency", a_word_valid, 1'b1);
        send(8'h32, 1'b0);
        send(8'h00, 1'b0);
        wait_done(1'b0, "t1");
        chk("t1_nwords", qa.size(), 32'd2);
        chk("t1_w0", qa[0], 16'h735E);
        chk("t1_w1", qa[1], 16'h3200);
        chk("t1_count", a_count, 8'd3);
        chk("t1_checksum", a_csum, 8'h1F);
        chk("t1_overflow", a_ovf, 1'b0);

        // 2: "ab"
        wait_idle();
        pulse_start();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h00, 1'b0);
        wait_done(1'b0, "t2");
        chk("t2_nwords", qa.size(), 32'd2);
        chk("t2_w0", qa[0], 16'h6162);
        chk("t2_w1", qa[1], 16'h0000);
        chk("t2_count", a_count, 8'd2);
        chk("t2_checksum", a_csum, 8'h03);

        // 3: empty string
        wait_idle();
        pulse_start();
        send(8'h00, 1'b0);
        wait_done(1'b0, "t3");
        chk("t3_nwords", qa.size(), 32'd1);
        chk("t3_w0", qa[0], 16'h0000);
        chk("t3_count", a_count, 8'd0);
        chk("t3_checksum", a_csum, 8'h00);
        chk("t3_overflow", a_ovf, 1'b0);

        // 4: back-pressure, FIFO fills after 8 chars
        wait_idle();
        word_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) send(8'h41 + 8'(i), 1'b0);
        chk("t4_full_char_ready", a_char_ready, 1'b0);
        chk("t4_full_word_valid", a_word_valid, 1'b1);
        word_ready = 1'b1;
        for (int i = 8; i < 12; i++) send(8'h41 + 8'(i), 1'b0);
        send(8'h00, 1'b0);
        wait_done(1'b0, "t4");
        chk("t4_nwords", qa.size(), 32'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("t4_w%0d", i), qa[i], exp4[i]);
        chk("t4_count", a_count, 8'd12);
        chk("t4_checksum", a_csum, 8'h0C);

        // 5: saturation on the MAX_CHARS=4 instance
        wait_idle();
        pulse_start();
        for (int i = 0; i < 6; i++) send(8'h31 + 8'(i), 1'b1);
        send(8'h00, 1'b1);
        wait_done(1'b1, "t5");
        chk("t5_nwords", qb.size(), 32'd3);
        chk("t5_w0", qb[0], 16'h3132);
        chk("t5_w1", qb[1], 16'h3334);
        chk("t5_w2", qb[2], 16'h0000);
        chk("t5_count", b_count, 8'd4);
        chk("t5_checksum", b_csum, 8'h04);
        chk("t5_overflow", b_ovf, 1'b1);

        // 6: reset mid-string with two words queued and a byte pending
        wait_idle();
        word_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 1'b0);
        chk("t6_pre_word_valid", a_word_valid, 1'b1);
        chk("t6_pre_busy", a_busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_word_valid", a_word_valid, 1'b0);
        chk("t6_busy", a_busy, 1'b0);
        chk("t6_char_ready", a_char_ready, 1'b0);
        chk("t6_count", a_count, 8'd0);
        chk("t6_checksum", a_csum, 8'h00);
        chk("t6_b_overflow", b_ovf, 1'b0);
        word_ready = 1'b1;
        tick();
        qa.delete();
        qb.delete();
        pulse_start();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h00, 1'b0);
        wait_done(1'b0, "t6");
        chk("t6_nwords", qa.size(), 32'd2);
        chk("t6_w0", qa[0], 16'h6162);
        chk("t6_w1", qa[1], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
